// File: rtl/mem_access_sequencer_if.sv
// Request/strobe bundle between the main control FSM, the memory-port sequencer and the address mux.
interface mem_access_sequencer_if;
  logic       fetch_req;
  logic       ld_req;
  logic       st_req;
  logic [1:0] addr_sel;
  logic       exc_div0;
  logic       exc_ovf;
  logic       exc_noop;
  logic [2:0] IorDControl;
  logic       MemWR;
  logic       IRWrite;
  logic       MDRWrite;
  logic       EPCWrite;
  logic       PCSrcExc;
  logic [1:0] exc_code;
  logic       busy;
  logic       done;

  modport master (
    output fetch_req, ld_req, st_req, addr_sel, exc_div0, exc_ovf, exc_noop,
    input  IorDControl, MemWR, IRWrite, MDRWrite, EPCWrite, PCSrcExc, exc_code, busy, done
  );

  modport slave (
    input  fetch_req, ld_req, st_req, addr_sel, exc_div0, exc_ovf, exc_noop,
    output IorDControl, MemWR, IRWrite, MDRWrite, EPCWrite, PCSrcExc, exc_code, busy, done
  );
endinterface

// File: rtl/mem_access_sequencer.sv
// Multicycle-CPU memory-port sequencer: fetch, load, store and exception-vector fetch with
// MEM_WAIT read wait states. All outputs are registered from the next-state decode.
module mem_access_sequencer #(
  parameter int unsigned MEM_WAIT = 2
) (
  input logic                   clk,
  input logic                   reset,
  mem_access_sequencer_if.slave bus_io
);

  localparam logic [3:0] StIdle  = 4'd0;
  localparam logic [3:0] StFWait = 4'd1;
  localparam logic [3:0] StFCap  = 4'd2;
  localparam logic [3:0] StDWait = 4'd3;
  localparam logic [3:0] StDCap  = 4'd4;
  localparam logic [3:0] StStore = 4'd5;
  localparam logic [3:0] StXEpc  = 4'd6;
  localparam logic [3:0] StXWait = 4'd7;
  localparam logic [3:0] StXCap  = 4'd8;

  localparam logic [3:0] CntInit = 4'(MEM_WAIT - 1);

  logic [3:0] state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [2:0] sel_q, sel_d;
  logic [1:0] code_q, code_d;
  logic [2:0] pend_q, pend_d;
  logic [2:0] clr;
  logic [2:0] data_sel;

  always_comb begin
    unique case (bus_io.addr_sel)
      2'd1:    data_sel = 3'b101;
      2'd2:    data_sel = 3'b110;
      default: data_sel = 3'b100;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sel_d   = sel_q;
    code_d  = code_q;
    clr     = 3'b000;
    unique case (state_q)
      StIdle: begin
        sel_d  = 3'b000;
        code_d = 2'd0;
        // Bit 0 div0, bit 1 ovf, bit 2 noop; lowest set bit wins.
        if (pend_q[0]) begin
          state_d = StXEpc;
          code_d  = 2'd1;
          clr     = 3'b001;
        end else if (pend_q[1]) begin
          state_d = StXEpc;
          code_d  = 2'd2;
          clr     = 3'b010;
        end else if (pend_q[2]) begin
          state_d = StXEpc;
          code_d  = 2'd3;
          clr     = 3'b100;
        end else if (bus_io.ld_req) begin
          state_d = StDWait;
          cnt_d   = CntInit;
          sel_d   = data_sel;
        end else if (bus_io.st_req) begin
          state_d = StStore;
          sel_d   = data_sel;
        end else if (bus_io.fetch_req) begin
          state_d = StFWait;
          cnt_d   = CntInit;
        end
      end
      StFWait: begin
        if (cnt_q == 4'd0) state_d = StFCap;
        else               cnt_d   = cnt_q - 4'd1;
      end
      StDWait: begin
        if (cnt_q == 4'd0) state_d = StDCap;
        else               cnt_d   = cnt_q - 4'd1;
      end
      StXEpc: begin
        state_d = StXWait;
        cnt_d   = CntInit;
        sel_d   = {1'b0, code_q};
      end
      StXWait: begin
        if (cnt_q == 4'd0) state_d = StXCap;
        else               cnt_d   = cnt_q - 4'd1;
      end
      StFCap, StDCap, StStore, StXCap: begin
        state_d = StIdle;
        sel_d   = 3'b000;
        code_d  = 2'd0;
      end
      default: begin
        state_d = StIdle;
        sel_d   = 3'b000;
        code_d  = 2'd0;
      end
    endcase
  end

  // A pulse coinciding with its own clear re-sets the flag.
  assign pend_d = (pend_q & ~clr) | {bus_io.exc_noop, bus_io.exc_ovf, bus_io.exc_div0};

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q            <= StIdle;
      cnt_q              <= 4'd0;
      sel_q              <= 3'b000;
      code_q             <= 2'd0;
      pend_q             <= 3'b000;
      bus_io.IorDControl <= 3'b000;
      bus_io.MemWR       <= 1'b0;
      bus_io.IRWrite     <= 1'b0;
      bus_io.MDRWrite    <= 1'b0;
      bus_io.EPCWrite    <= 1'b0;
      bus_io.PCSrcExc    <= 1'b0;
      bus_io.exc_code    <= 2'd0;
      bus_io.busy        <= 1'b0;
      bus_io.done        <= 1'b0;
    end else begin
      state_q            <= state_d;
      cnt_q              <= cnt_d;
      sel_q              <= sel_d;
      code_q             <= code_d;
      pend_q             <= pend_d;
      bus_io.IorDControl <= sel_d;
      bus_io.MemWR       <= (state_d == StStore);
      bus_io.IRWrite     <= (state_d == StFCap);
      bus_io.MDRWrite    <= (state_d == StDCap) || (state_d == StXCap);
      bus_io.EPCWrite    <= (state_d == StXEpc);
      bus_io.PCSrcExc    <= (state_d == StXCap);
      bus_io.exc_code    <= code_d;
      bus_io.busy        <= (state_d != StIdle);
      bus_io.done        <= (state_d == StFCap) || (state_d == StDCap) ||
                            (state_d == StStore) || (state_d == StXCap);
    end
  end

endmodule
